// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART TX and RX paths.
//   - PRESCALE_8/16/32 : the only legal UCLK-cycles-per-bit encodings
//   - tx_state_t       : transmitter FSM states
//   - PAR_EVEN/PAR_ODD : parity type selector values
//   - prescale_legal() : 1 when a prescale value is one of the legal encodings
package uart_pkg;

    localparam logic [5:0] PRESCALE_8  = 6'b00_1000;
    localparam logic [5:0] PRESCALE_16 = 6'b01_0000;
    localparam logic [5:0] PRESCALE_32 = 6'b10_0000;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit cycle counter for the UART transmitter.
// Ports:
//   UCLK     in  UART clock
//   reset    in  asynchronous active-high reset
//   en       in  count enable (frame in progress)
//   clr      in  synchronous clear, wins over en
//   prescale in  latched cycles-per-bit (8, 16 or 32)
//   bit_done out 1 in the last cycle of each bit period
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic       UCLK,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [5:0] prescale,
    output logic       bit_done
);

    logic [4:0] count;
    logic [5:0] last_full;
    logic [4:0] last;

    // prescale-1 is at most 31, so the top bit of the 6-bit difference is
    // always zero for legal values and can be dropped.
    assign last_full = prescale - 6'd1;
    assign last      = last_full[4:0];
    assign bit_done  = en && (count == last);

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            count <= 5'd0;
        end else if (clr) begin
            count <= 5'd0;
        end else if (en) begin
            if (count == last) begin
                count <= 5'd0;
            end else begin
                count <= count + 5'd1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, 8N1 or 8P1 framing, LSB first.
// Ports:
//   UCLK     in  UART clock shared with the RX path
//   reset    in  asynchronous active-high reset
//   prescale in  UCLK cycles per bit (8, 16 or 32; anything else blocks TX)
//   par_en   in  1 = append a parity bit after the data bits
//   par_typ  in  0 = even parity, 1 = odd parity
//   tx_valid in  upstream offers tx_data
//   tx_data  in  byte to send
//   tx_ready out block accepts a byte this cycle (combinational)
//   tx_out   out serial line, idle high, registered
//   busy     out a frame is in progress
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    tx_state_t             state;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [5:0]            prescale_q;
    logic                  accept;
    logic                  bit_done;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign tx_ready = (state == IDLE) && !reset && prescale_legal(prescale);
    assign accept   = tx_valid && tx_ready;

    // The timer is held at zero while idle so the start bit gets a full period.
    uart_tx_bit_timer u_bit_timer (
        .UCLK     (UCLK),
        .reset    (reset),
        .en       (state != IDLE),
        .clr      (state == IDLE),
        .prescale (prescale_q),
        .bit_done (bit_done)
    );

    // Frame parameters are captured once per acceptance; later input changes
    // only affect the next frame.
    always_ff @(posedge UCLK) begin
        if (accept) begin
            data_q     <= tx_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            prescale_q <= prescale;
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= START;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx_out  <= data_q[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_LAST) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= parity_bit(data_q, par_typ_q);
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                            tx_out  <= data_q[bit_idx + IDX_ONE];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic       UCLK = 1'b0;
    logic       reset;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Serial bits in send order: bits[0] is the start bit, bits[1..8] the
    // data LSB first, then parity (if any) and stop; unused top bits are 1.
    typedef struct {
        logic [5:0]  pre;
        logic        pe;
        logic        pt;
        logic [7:0]  data;
        logic [10:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs[4];

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .UCLK     (UCLK),
        .reset    (reset),
        .prescale (prescale),
        .par_en   (par_en),
        .par_typ  (par_typ),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    always #5 UCLK = ~UCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Call at the negedge where tx_valid was just raised with tx_ready=1.
    // Checks every cycle of the frame plus the idle cycle that follows.
    // At n==0 tx_data takes next_data and tx_valid takes keep_valid; at
    // n==mut_at the frame inputs are scrambled to prove they were latched.
    task automatic run_frame(input string tag, input logic [10:0] bits, input int nbits,
                             input int p, input logic keep_valid,
                             input logic [7:0] next_data, input int mut_at);
        for (int n = 0; n < nbits * p; n++) begin
            @(negedge UCLK);
            chk({tag, ".tx_out"}, tx_out, bits[n / p]);
            chk({tag, ".busy"}, busy, 1'b1);
            chk({tag, ".tx_ready"}, tx_ready, 1'b0);
            if (n == 0) begin
                tx_valid = keep_valid;
                tx_data  = next_data;
            end
            if (n == mut_at) begin
                tx_data  = 8'hFF;
                par_en   = 1'b0;
                par_typ  = 1'b1;
                prescale = 6'd8;
            end
        end
        @(negedge UCLK);
        chk({tag, ".idle_tx_out"}, tx_out, 1'b1);
        chk({tag, ".idle_busy"}, busy, 1'b0);
        chk({tag, ".idle_ready"}, tx_ready, 1'b1);
    endtask

    task automatic offer(input logic [5:0] pre, input logic pe, input logic pt,
                         input logic [7:0] d);
        prescale = pre;
        par_en   = pe;
        par_typ  = pt;
        tx_data  = d;
        tx_valid = 1'b1;
        #1;
        chk("offer.tx_ready", tx_ready, 1'b1);
    endtask

    initial begin
        vecs[0] = '{pre: 6'd8,  pe: 1'b0, pt: 1'b0, data: 8'hA5,
                    bits: 11'b11_10100101_0, nbits: 10};
        vecs[1] = '{pre: 6'd16, pe: 1'b1, pt: 1'b0, data: 8'h07,
                    bits: 11'b1_1_00000111_0, nbits: 11};
        vecs[2] = '{pre: 6'd16, pe: 1'b1, pt: 1'b1, data: 8'h07,
                    bits: 11'b1_0_00000111_0, nbits: 11};
        vecs[3] = '{pre: 6'd32, pe: 1'b1, pt: 1'b1, data: 8'h3C,
                    bits: 11'b1_1_00111100_0, nbits: 11};

        // Reset state, with a legal offer pending
        reset    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        repeat (3) @(negedge UCLK);
        chk("rst.tx_out", tx_out, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.tx_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge UCLK);
        chk("post_rst.tx_ready", tx_ready, 1'b1);
        chk("post_rst.tx_out", tx_out, 1'b1);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            offer(vecs[i].pre, vecs[i].pe, vecs[i].pt, vecs[i].data);
            run_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits,
                      int'(vecs[i].pre), 1'b0, vecs[i].data, -1);
        end

        // Back-to-back at prescale 32 with tx_valid held: one idle cycle between
        offer(6'd32, 1'b0, 1'b0, 8'h00);
        run_frame("b2b0", 11'b11_00000000_0, 10, 32, 1'b1, 8'hFF, -1);
        run_frame("b2b1", 11'b11_11111111_0, 10, 32, 1'b0, 8'hFF, -1);

        // Illegal prescale blocks acceptance
        prescale = 6'd12;
        par_en   = 1'b0;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge UCLK);
            chk("bad_pre.tx_ready", tx_ready, 1'b0);
            chk("bad_pre.tx_out", tx_out, 1'b1);
            chk("bad_pre.busy", busy, 1'b0);
        end
        offer(6'd8, 1'b0, 1'b0, 8'h5A);
        run_frame("after_bad_pre", 11'b11_01011010_0, 10, 8, 1'b0, 8'h5A, -1);

        // Reset during DATA bit 3 of 8'h3C
        offer(6'd8, 1'b0, 1'b0, 8'h3C);
        for (int n = 0; n < 8 + 3 * 8 + 2; n++) @(negedge UCLK);
        chk("pre_abort.busy", busy, 1'b1);
        chk("pre_abort.tx_out", tx_out, 1'b1);
        tx_valid = 1'b0;
        #2;
        chk("pre_abort.bit2_seen", 32'(dut.state), 32'd2);
        reset = 1'b1;
        #1;
        chk("abort.tx_out", tx_out, 1'b1);
        chk("abort.busy", busy, 1'b0);
        chk("abort.tx_ready", tx_ready, 1'b0);
        repeat (2) @(negedge UCLK);
        reset = 1'b0;
        #1;
        chk("abort_rel.tx_ready", tx_ready, 1'b1);
        offer(6'd8, 1'b0, 1'b0, 8'h3C);
        run_frame("after_abort", 11'b11_00111100_0, 10, 8, 1'b0, 8'h3C, -1);

        // Mid-frame input changes leave the current frame alone
        offer(6'd16, 1'b1, 1'b0, 8'h07);
        run_frame("midchg", 11'b1_1_00000111_0, 11, 16, 1'b0, 8'h07, 40);
        // The scrambled values (FF, no parity, prescale 8) apply to the next one
        tx_valid = 1'b1;
        #1;
        chk("midchg_next.tx_ready", tx_ready, 1'b1);
        run_frame("midchg_next", 11'b11_11111111_0, 10, 8, 1'b0, 8'hFF, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmitter for the UART side of the APB-UART bridge. It is the counterpart of the RX path.
- Accepts one parallel byte per valid/ready handshake.
- Serializes it LSB-first: start bit, 8 data bits, optional parity bit, one stop bit.
- Each bit is held for exactly `prescale` UCLK cycles. This matches the RX oversampling ratio, so TX and RX share one UCLK and one prescale register.

Parameters:
DATA_WIDTH, 8, payload bits per frame (only 8 is supported and verified)

Ports:
UCLK  input  1  UART clock, shared with the RX path
reset  input  1  asynchronous, active-high reset
prescale  input  6  cycles per bit; legal values 8, 16, 32 (6'b00_1000, 6'b01_0000, 6'b10_0000)
par_en  input  1  1 = insert a parity bit after the data bits
par_typ  input  1  0 = even parity, 1 = odd parity
tx_valid  input  1  upstream holds a byte for transmission
tx_data  input  DATA_WIDTH  byte to send
tx_ready  output  1  block can accept a byte this cycle
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, tx_out=1, busy=0, tx_ready=0 while reset is asserted.
  - Bit timer and bit index cleared.
  - Reset asserted mid-frame aborts the frame immediately; tx_out returns to 1 asynchronously.
- tx_ready is combinational: 1 only when state==IDLE, reset==0, and prescale is legal. Illegal prescale means no frame ever starts.
- Acceptance happens on a UCLK edge where tx_valid & tx_ready.
  - tx_data, par_en, par_typ and prescale are latched on that edge.
  - Mid-frame changes to these inputs have no effect on the current frame.
- Registered output: tx_out drives the start bit (0) from the cycle after acceptance.
- FSM: IDLE -> START -> DATA -> (PARITY if par_en latched) -> STOP -> IDLE.
  - Each non-IDLE state lasts exactly prescale cycles.
  - DATA lasts 8*prescale cycles: bit index 0..7, tx_out = data[index].
  - PARITY: tx_out = ^data for even, ~^data for odd.
  - STOP: tx_out = 1.
- Bit timer:
  - Counts 0..prescale-1 and wraps to 0.
  - bit_done pulses when count == prescale-1, i.e. 7, 15 or 31.
  - The FSM advances state or bit index only on bit_done.
- Frame length: (10 + par_en) * prescale cycles of non-IDLE.
- After the last STOP cycle the FSM enters IDLE for at least one cycle, with tx_out=1 and tx_ready=1. Back-to-back frames are therefore separated by exactly one UCLK cycle of idle-high when tx_valid stays asserted.
- busy = (state != IDLE). It rises the cycle after acceptance and falls on entry to IDLE.
- tx_valid held while tx_ready=0: the byte is not consumed. Upstream must hold tx_data stable until acceptance.

Decomposition:
- Shared package uart_pkg:
  - Prescale encodings PRESCALE_8/16/32.
  - TX FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - The RX path uses the same constants.
- Sub-module uart_tx_bit_timer: 5-bit counter with enable and synchronous clear, producing bit_done from the latched prescale.
- FSM, shift/index logic and parity generation stay in uart_tx_core.

Test Plan:
- prescale=8, par_en=0, send 8'hA5 -> tx_out low 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), then high 8 cycles. busy high for 80 cycles, then tx_ready=1.
- prescale=16, par_en=1, par_typ=0, send 8'h07 -> parity bit = 1; frame is 176 cycles. Repeat with par_typ=1 -> parity bit = 0.
- prescale=32, tx_valid held, bytes 8'h00 then 8'hFF -> two 320-cycle frames separated by exactly one idle-high cycle. Second frame's data bits are all 1.
- prescale=6'd12 with tx_valid=1 -> tx_ready stays 0, tx_out stays 1, busy stays 0 for 100 cycles. Changing to 8 accepts the byte on the next edge.
- Assert reset during DATA bit 3 of 8'h3C -> tx_out=1 and busy=0 immediately. After release, an 8'h3C frame transmits complete and correct.
- Change tx_data, par_en and prescale mid-frame -> current frame is unchanged (latched values used). The new values apply to the next acceptance only.
